// File: rtl/strobe_pkg.sv
// Shared types and default timing constants for the strobe burst transmitter.
package strobe_pkg;

    localparam int unsigned PULSES_DEF       = 6;
    localparam int unsigned HIGH_CYC_DEF     = 4;
    localparam int unsigned LOW_CYC_DEF      = 4;
    localparam int unsigned COOLDOWN_CYC_DEF = 20000002;
    localparam int unsigned PULSE_CNT_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIGH = 3'd1,
        ST_LOW  = 3'd2,
        ST_COOL = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/strobe_timer.sv
// Loadable down-counter that saturates at zero; o_zero_c flags the final cycle of a phase.
module strobe_timer #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_en,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/strobe_burst_tx.sv
// Emits PULSES strobe pulses per request, then enforces a cooldown before DONE.
// Optional macro STB_REQ_QUEUE_EN adds a one-deep pending-request flag.
module strobe_burst_tx
    import strobe_pkg::*;
#(
    parameter int unsigned PULSES       = PULSES_DEF,
    parameter int unsigned HIGH_CYC     = HIGH_CYC_DEF,
    parameter int unsigned LOW_CYC      = LOW_CYC_DEF,
    parameter int unsigned COOLDOWN_CYC = COOLDOWN_CYC_DEF
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic REQ,
    output logic STB,
    output logic BUSY,
    output logic DONE
);

    localparam int unsigned TW = $clog2(COOLDOWN_CYC + 1);
    localparam int unsigned CW = PULSE_CNT_W;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_pulse_cnt;
    logic [CW-1:0] w_pulse_cnt_nxt;
    logic [CW-1:0] w_sent;
    logic [TW-1:0] w_value;
    logic          w_load;
    logic          w_zero;
    logic          w_tmr_en;
    logic          w_pend;
    logic          w_start;
    logic          r_stb;
    logic          r_busy;
    logic          r_done;

`ifdef STB_REQ_QUEUE_EN
    logic r_pend;
    logic w_pend_nxt;

    // Capture at most one request seen while busy; consumed on the next IDLE cycle.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_state == ST_IDLE) begin
            w_pend_nxt = 1'b0;
        end else if (REQ) begin
            w_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign w_pend = r_pend;
`else
    assign w_pend = 1'b0;
`endif

    assign w_start  = REQ | w_pend;
    assign w_sent   = r_pulse_cnt + CW'(1);
    assign w_tmr_en = (r_state != ST_IDLE);

    strobe_timer #(
        .W (TW)
    ) u_timer (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_load   (w_load),
        .i_value  (w_value),
        .i_en     (w_tmr_en),
        .o_zero_c (w_zero)
    );

    // Next state; the timer is reloaded with the new phase length on every transition.
    always_comb begin
        w_state_nxt     = r_state;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_load          = 1'b0;
        w_value         = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt     = ST_HIGH;
                    w_pulse_cnt_nxt = '0;
                    w_load          = 1'b1;
                    w_value         = TW'(HIGH_CYC - 1);
                end
            end
            ST_HIGH: begin
                if (w_zero) begin
                    w_pulse_cnt_nxt = w_sent;
                    w_load          = 1'b1;
                    if (w_sent < CW'(PULSES)) begin
                        w_state_nxt = ST_LOW;
                        w_value     = TW'(LOW_CYC - 1);
                    end else begin
                        w_state_nxt = ST_COOL;
                        w_value     = TW'(COOLDOWN_CYC - 1);
                    end
                end
            end
            ST_LOW: begin
                if (w_zero) begin
                    w_state_nxt = ST_HIGH;
                    w_load      = 1'b1;
                    w_value     = TW'(HIGH_CYC - 1);
                end
            end
            ST_COOL: begin
                if (w_zero) begin
                    w_state_nxt = ST_FIN;
                    w_load      = 1'b1;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_pulse_cnt <= '0;
            r_stb       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
            r_stb       <= (w_state_nxt == ST_HIGH);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_FIN);
        end
    end

    assign STB  = r_stb;
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_strobe_burst_tx.sv
// Randomized bench for strobe_burst_tx against a burst-offset reference model.
module tb_strobe_burst_tx;

    localparam int P   = 4;
    localparam int H   = 3;
    localparam int LO  = 2;
    localparam int C   = 12;
    localparam int ACT = P * H + (P - 1) * LO;
    localparam int L   = ACT + C + 1;
    localparam int H1  = 2;
`ifdef STB_REQ_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic req;
    logic req1;
    logic stb, busy, done;
    logic stb1, busy1, done1;

    always #5 clk = ~clk;

    strobe_burst_tx #(
        .PULSES       (P),
        .HIGH_CYC     (H),
        .LOW_CYC      (LO),
        .COOLDOWN_CYC (C)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .REQ   (req),
        .STB   (stb),
        .BUSY  (busy),
        .DONE  (done)
    );

    strobe_burst_tx #(
        .PULSES       (1),
        .HIGH_CYC     (H1),
        .LOW_CYC      (2),
        .COOLDOWN_CYC (5)
    ) dut1 (
        .CLK   (clk),
        .RST_N (rst_n),
        .REQ   (req1),
        .STB   (stb1),
        .BUSY  (busy1),
        .DONE  (done1)
    );

    // Reference: a burst is a fixed waveform indexed by the cycle offset since it started.
    bit m_active = 1'b0;
    bit m_pend   = 1'b0;
    int m_off    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_pend   <= 1'b0;
            m_off    <= 0;
        end else if (!m_active) begin
            if (req || m_pend) begin
                m_active <= 1'b1;
                m_off    <= 0;
                m_pend   <= 1'b0;
            end
        end else begin
            if (QUEUE && req) m_pend <= 1'b1;
            if (m_off == L - 1) begin
                m_active <= 1'b0;
                m_off    <= 0;
            end else begin
                m_off <= m_off + 1;
            end
        end
    end

    function automatic logic [2:0] exp_out(input bit act, input int off);
        logic s;
        if (!act) return 3'b000;
        s = (off < ACT) && ((off % (H + LO)) < H);
        return {s, 1'b1, (off == L - 1)};
    endfunction

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rise_cnt = 0, done_cnt = 0, busy_cnt = 0, done_gap = 0, last_high = 0;
    int low_run = 0;
    bit fell = 1'b0;
    logic prev_stb = 1'b0;
    logic prev1 = 1'b0;
    bit have1 = 1'b0;
    bit rst_seen = 1'b0;
    int last1 = 0, rises1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the model plus the monitors and burst statistics.
    task automatic sample();
        check("outputs", 32'({stb, busy, done}), 32'(exp_out(m_active, m_off)));
        if (!busy) begin
            fell = 1'b0;
        end else if (stb && !prev_stb && fell) begin
            check("min_low_time", 32'(low_run >= LO), 32'd1);
        end
        if (!stb && prev_stb) begin
            fell    = 1'b1;
            low_run = 1;
        end else if (!stb) begin
            low_run++;
        end
        if (busy) busy_cnt++;
        if (stb && !prev_stb) rise_cnt++;
        if (stb) last_high = cyc;
        if (done) begin
            done_cnt++;
            done_gap = cyc - last_high;
        end
        prev_stb = stb;

        if (!rst_n || rst_seen) begin
            have1    = 1'b0;
            rst_seen = 1'b0;
        end else if (stb1 && !prev1) begin
            if (have1) check("held_req_period", 32'(cyc - last1), 32'd9);
            have1 = 1'b1;
            last1 = cyc;
            rises1++;
        end
        prev1 = stb1;
        cyc++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            sample();
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step(1);
        req = 1'b0;
    endtask

    int r0, d0, b0;

    initial begin
        rst_n = 1'b1;
        req   = 1'b0;
        req1  = 1'b0;
        #1 rst_n = 1'b0;
        step(3);
        check("reset_outputs", 32'({stb, busy, done}), 32'd0);
        check("reset_outputs_dut1", 32'({stb1, busy1, done1}), 32'd0);
        rst_n = 1'b1;
        req1  = 1'b1;
        step(3);

        // Single request: latency, pulse count, busy length, done placement.
        r0 = rise_cnt; d0 = done_cnt; b0 = busy_cnt;
        req = 1'b1;
        step(1);
        req = 1'b0;
        check("first_stb_latency", 32'(stb), 32'd1);
        check("busy_at_start", 32'(busy), 32'd1);
        step(L + 5);
        check("pulse_count", 32'(rise_cnt - r0), 32'd4);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("busy_cycles", 32'(busy_cnt - b0), 32'd31);
        check("done_after_last_high", 32'(done_gap), 32'd13);

        // Three requests within one burst: only one can be queued.
        r0 = rise_cnt; d0 = done_cnt;
        pulse_req();
        step(5);
        pulse_req();
        step(8);
        pulse_req();
        step(2 * L + 10);
        check("busy_req_bursts", 32'(done_cnt - d0), QUEUE ? 32'd2 : 32'd1);
        check("busy_req_pulses", 32'(rise_cnt - r0), QUEUE ? 32'd8 : 32'd4);

        // Request landing exactly in the DONE cycle.
        d0 = done_cnt;
        pulse_req();
        step(L - 1);
        check("fin_alignment", 32'(done), 32'd1);
        pulse_req();
        step(2 * L + 10);
        check("fin_req_bursts", 32'(done_cnt - d0), QUEUE ? 32'd2 : 32'd1);

        // Asynchronous reset during the third high phase.
        pulse_req();
        step(11);
        check("third_high", 32'(stb), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_stb", 32'(stb), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        step(3);
        rst_n = 1'b1;
        r0 = rise_cnt;
        step(1000);
        check("no_pulse_after_reset", 32'(rise_cnt - r0), 32'd0);

        // Random requests with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 29) == 0) || (req && ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 999) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
                rst_seen = 1'b1;
            end
            step(1);
        end
        req = 1'b0;
        step(L + 5);

        check("held_req_live", 32'(rises1 > 100), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
